// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage types and constants.
package fetch_unit_pkg;
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD} fetch_state_e;
  localparam logic [31:0] NOP_INST = 32'h0;
  localparam logic [31:0] PC_INC   = 32'd4;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int IMM_W    = 16;
  localparam int JIDX_W   = 26;
  function automatic logic [31:0] align4(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// next_pc_sel: redirect target priority mux (Jr > Jump > Branch) with word alignment.
module next_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic              Jr,
  input  logic [31:0]       Jr_Target,
  input  logic              Jump,
  input  logic [JIDX_W-1:0] Jump_Target,
  input  logic              Branch_Taken,
  input  logic [31:0]       Branch_Target,
  input  logic [31:0]       PC_ID,
  output logic              Redirect_Req,
  output logic [31:0]       Redirect_Target
);
  logic unused_pc_low;
  assign unused_pc_low = ^PC_ID[27:0];
  always_comb begin
    Redirect_Req    = Jr || Jump || Branch_Taken;
    Redirect_Target = align4(Jr ? Jr_Target :
                             Jump ? {PC_ID[31:28], Jump_Target, 2'b00} : Branch_Target);
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and req/ack instruction-memory front end feeding IF/ID.
// Optional FETCH_PERF_CNT_EN adds Fetch_Count/Stall_Count performance counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Stall_ID,
  input  logic              Branch_Taken,
  input  logic [31:0]       Branch_Target,
  input  logic              Jump,
  input  logic [JIDX_W-1:0] Jump_Target,
  input  logic              Jr,
  input  logic [31:0]       Jr_Target,
  input  logic [31:0]       PC_ID,
  input  logic              Imem_Ack,
  input  logic [31:0]       Imem_Rdata,
  output logic              Imem_Req,
  output logic [31:0]       Imem_Addr,
  output logic [31:0]       PC_IF,
  output logic [31:0]       PC_4,
  output logic [31:0]       Inst,
  output logic              IF_Flush,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       Fetch_Count,
  output logic [31:0]       Stall_Count,
`endif
  output logic              IF_stall
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, buf_q, buf_d, redir_target;
  logic redir_req, redirect, inst_valid, consume, capture;

  next_pc_sel u_sel (
    .Jr(Jr), .Jr_Target(Jr_Target), .Jump(Jump), .Jump_Target(Jump_Target),
    .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target), .PC_ID(PC_ID),
    .Redirect_Req(redir_req), .Redirect_Target(redir_target)
  );

  always_comb begin
    inst_valid = (state_q == S_FETCH && Imem_Ack) || state_q == S_HOLD;
    redirect   = redir_req && !Stall_ID;
    consume    = inst_valid && !Stall_ID;
    capture    = state_q == S_FETCH && Imem_Ack && Stall_ID;
    PC_IF      = pc_q;
    PC_4       = pc_q + PC_INC;
    Imem_Addr  = pc_q;
    Imem_Req   = state_q == S_FETCH;
    Inst       = state_q == S_FETCH ? Imem_Rdata : buf_q;
    IF_stall   = !inst_valid || Stall_ID;
    // Rst_n gate keeps the flush quiet while the stage is held in reset
    IF_Flush   = redirect && Rst_n;
    pc_d       = redirect ? redir_target : consume ? PC_4 : pc_q;
    state_d    = (redirect || consume || state_q == S_BOOT) ? S_FETCH :
                 capture ? S_HOLD : state_q;
    buf_d      = capture ? Imem_Rdata : buf_q;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_INST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + {31'd0, consume && !redirect};
      stall_cnt_q <= stall_cnt_q + {31'd0, IF_stall && state_q != S_BOOT};
    end
  end
  assign Fetch_Count = fetch_cnt_q;
  assign Stall_Count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit.
module tb_fetch_unit;
  logic        Clk = 0, Rst_n, Stall_ID, Branch_Taken, Jump, Jr, Imem_Ack;
  logic [31:0] Branch_Target, Jr_Target, PC_ID, Imem_Rdata;
  logic [25:0] Jump_Target;
  logic        Imem_Req, IF_Flush, IF_stall;
  logic [31:0] Imem_Addr, PC_IF, PC_4, Inst;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] Fetch_Count, Stall_Count;
`endif
  int total = 0, bad = 0;

  typedef struct { string tag; logic [31:0] v; } exp_t;
  exp_t sb[$];

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall_ID(Stall_ID), .Branch_Taken(Branch_Taken),
    .Branch_Target(Branch_Target), .Jump(Jump), .Jump_Target(Jump_Target),
    .Jr(Jr), .Jr_Target(Jr_Target), .PC_ID(PC_ID), .Imem_Ack(Imem_Ack),
    .Imem_Rdata(Imem_Rdata), .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
    .PC_IF(PC_IF), .PC_4(PC_4), .Inst(Inst), .IF_Flush(IF_Flush),
`ifdef FETCH_PERF_CNT_EN
    .Fetch_Count(Fetch_Count), .Stall_Count(Stall_Count),
`endif
    .IF_stall(IF_stall)
  );

  always #5 Clk = ~Clk;

  task automatic push(input string t, input logic [31:0] v);
    sb.push_back('{t, v});
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty got=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s got=%h exp=%h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic next();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst_n = 0; Stall_ID = 0; Branch_Taken = 0; Jump = 1; Jr = 0; Imem_Ack = 1;
    Branch_Target = 0; Jr_Target = 0; PC_ID = 0; Jump_Target = 0;
    Imem_Rdata = 32'h2002_0005;
    #2;
    push("rst_pc", 0); push("rst_pc4", 4); push("rst_req", 0);
    push("rst_stall", 1); push("rst_inst", 0); push("rst_flush", 0);
    chk(PC_IF); chk(PC_4); chk({31'd0, Imem_Req}); chk({31'd0, IF_stall}); chk(Inst); chk({31'd0, IF_Flush});
    Jump = 0;
    next(); Rst_n = 1; #1;
    push("boot_req", 0); push("boot_stall", 1);
    chk({31'd0, Imem_Req}); chk({31'd0, IF_stall});
    // zero-wait sequential fetch
    for (int i = 0; i < 3; i++) begin
      next(); #1;
      push("seq_req", 1); push("seq_addr", 32'(i * 4)); push("seq_pc4", 32'(i * 4 + 4));
      push("seq_stall", 0); push("seq_inst", 32'h2002_0005);
      chk({31'd0, Imem_Req}); chk(Imem_Addr); chk(PC_4); chk({31'd0, IF_stall}); chk(Inst);
    end
    // three wait cycles at PC 8
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next();
      Imem_Ack = 0; #1;
      push("wait_stall", 1); push("wait_pc", 8);
      chk({31'd0, IF_stall}); chk(PC_IF);
      if (i == 0) next();
    end
    next(); Imem_Ack = 1; Imem_Rdata = 32'h1234_5678; #1;
    push("ack_inst", 32'h1234_5678); push("ack_stall", 0); push("ack_addr", 8);
    chk(Inst); chk({31'd0, IF_stall}); chk(Imem_Addr);
    // capture under ID stall then hold
    next(); Imem_Rdata = 32'h8C43_0010; Stall_ID = 1; #1;
    push("cap_addr", 32'hC); push("cap_stall", 1); push("cap_inst", 32'h8C43_0010);
    chk(Imem_Addr); chk({31'd0, IF_stall}); chk(Inst);
    next(); Imem_Rdata = 32'hFFFF_FFFF; #1;
    push("hold_req", 0); push("hold_inst", 32'h8C43_0010); push("hold_pc", 32'hC);
    chk({31'd0, Imem_Req}); chk(Inst); chk(PC_IF);
    next(); Stall_ID = 0; #1;
    push("rel_inst", 32'h8C43_0010); push("rel_stall", 0);
    chk(Inst); chk({31'd0, IF_stall});
    next(); #1;
    push("rel_addr", 32'h10); push("rel_req", 1);
    chk(Imem_Addr); chk({31'd0, Imem_Req});
    // jump beats branch
    Jump = 1; PC_ID = 32'h1000_0004; Jump_Target = 26'h000_0040;
    Branch_Taken = 1; Branch_Target = 32'h5555_0000; #1;
    push("j_flush", 1); chk({31'd0, IF_Flush});
    next(); Jump = 0; Branch_Taken = 0; #1;
    push("j_addr", 32'h1000_0100); push("j_flush0", 0);
    chk(Imem_Addr); chk({31'd0, IF_Flush});
    // jr with misaligned register value
    Jr = 1; Jr_Target = 32'h0000_2003; #1;
    push("jr_flush", 1); chk({31'd0, IF_Flush});
    next(); Jr = 0; #1;
    push("jr_addr", 32'h2000); chk(Imem_Addr);
    // redirect ignored while ID stalled
    Jump = 1; Stall_ID = 1; #1;
    push("js_flush", 0); push("js_stall", 1);
    chk({31'd0, IF_Flush}); chk({31'd0, IF_stall});
    next(); Jump = 0; Stall_ID = 0; #1;
    push("js_pc", 32'h2000); chk(PC_IF);
    next(); #1;
    push("js_next", 32'h2004); chk(PC_IF);
    // wraparound
    Jr = 1; Jr_Target = 32'hFFFF_FFFC;
    next(); Jr = 0; #1;
    push("wrap_pc", 32'hFFFF_FFFC); push("wrap_pc4", 0);
    chk(PC_IF); chk(PC_4);
    next(); #1;
    push("wrap_next", 0); chk(PC_IF);
    // async reset during a waiting fetch
    next(); Imem_Ack = 0; #1;
    push("w2_pc", 4); push("w2_stall", 1);
    chk(PC_IF); chk({31'd0, IF_stall});
    #1 Rst_n = 0; #1;
    push("ar_pc", 0); push("ar_req", 0); push("ar_stall", 1); push("ar_inst", 0);
    chk(PC_IF); chk({31'd0, Imem_Req}); chk({31'd0, IF_stall}); chk(Inst);
    next(); Rst_n = 1;
    if (sb.size() != 0) begin
      bad++;
      $error("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the program counter and drives a request/acknowledge instruction-memory port. It selects the next PC from sequential, branch, jump and jump-register sources. It produces PC_4, Inst, IF_Flush and IF_stall, which the IF/ID register consumes.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
Clk  input  1  clock; all state updates on posedge.
Rst_n  input  1  asynchronous, active-low reset.
Stall_ID  input  1  hazard-unit stall of the ID stage.
Branch_Taken  input  1  branch in ID resolved taken.
Branch_Target  input  32  full branch target from ID.
Jump  input  1  J/JAL in ID.
Jump_Target  input  26  jump index field from ID.
Jr  input  1  JR/JALR in ID.
Jr_Target  input  32  register value for JR.
PC_ID  input  32  PC+4 of the instruction currently in ID.
Imem_Ack  input  1  Imem_Rdata is valid for this cycle's Imem_Addr.
Imem_Rdata  input  32  instruction word.
Imem_Req  output  1  fetch request.
Imem_Addr  output  32  fetch address; always equals PC_IF.
PC_IF  output  32  current PC.
PC_4  output  32  PC_IF+4, to IF/ID.
Inst  output  32  fetched instruction, to IF/ID.
IF_Flush  output  1  squash the IF/ID load this cycle.
IF_stall  output  1  hold IF/ID this cycle.

Behaviour:
- Clock and reset: one clock, Clk. Rst_n is asynchronous, active-low; assertion takes effect immediately, independent of Clk.
- Reset values: PC_IF=RESET_PC, PC_4=RESET_PC+4, state=S_BOOT, Inst_buf=0. Outputs during reset: Inst=0, Imem_Req=0, IF_Flush=0, IF_stall=1.
- States:
  - S_BOOT: Imem_Req=0. Goes unconditionally to S_FETCH on the first edge after reset release.
  - S_FETCH: Imem_Req=1.
  - S_HOLD: an instruction is captured and waiting for ID. Imem_Req=0.
- Inst_Valid = (S_FETCH && Imem_Ack) || S_HOLD.
- Inst = Imem_Rdata in S_FETCH; Inst_buf otherwise.
- IF_stall = !Inst_Valid || Stall_ID.
- Redirect = (Jr || Jump || Branch_Taken) && !Stall_ID. Redirect inputs are ignored while Stall_ID=1.
- Redirect target priority: Jr > Jump > Branch_Taken.
  - Jr: Jr_Target.
  - Jump: {PC_ID[31:28], Jump_Target, 2'b00}.
  - Branch: Branch_Target.
  - Bits [1:0] of every target are forced to 00.
- IF_Flush = Redirect, combinational, same cycle as the redirect request.
- Posedge update, first matching rule applies:
  1. Redirect: PC_IF<=target, state<=S_FETCH. Any Ack this cycle is discarded; any outstanding fetch is abandoned.
  2. Inst_Valid && !Stall_ID: PC_IF<=PC_IF+4, state<=S_FETCH (instruction consumed).
  3. S_FETCH && Imem_Ack && Stall_ID: Inst_buf<=Imem_Rdata, state<=S_HOLD.
  4. Otherwise: hold all state.
- Latency: zero-wait memory (Imem_Ack tied 1) delivers one instruction per cycle. Each wait cycle adds one IF_stall cycle.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Imem protocol: Ack qualifies only the address of the same cycle. The address may change on redirect without Ack; the memory treats a new address as a new request.
- Reset asserted mid-fetch or in S_HOLD: immediate return to reset values; Inst_buf is cleared.

Optional Feature:
- FETCH_PERF_CNT_EN defined: adds outputs Fetch_Count[31:0] and Stall_Count[31:0].
  - Fetch_Count increments on every rule-2 edge.
  - Stall_Count increments on every edge where IF_stall=1 outside S_BOOT.
  - Both are reset to 0 and wrap modulo 2^32.
- Macro undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package:
  - fetch state typedef (S_BOOT, S_FETCH, S_HOLD).
  - NOP_INST=32'h0.
  - PC_INC=32'd4.
  - Opcode/field width constants shared with the decode stages.
- Sub-module next_pc_sel: combinational target priority mux and alignment. Inputs are Jr/Jump/Branch and their targets plus PC_ID; outputs are Redirect_Req and Redirect_Target.

Test Plan:
- Rst_n=0, then release → during reset PC_IF=0, Imem_Req=0, IF_stall=1; one S_BOOT cycle follows, then Imem_Req=1 with Imem_Addr=0.
- Imem_Ack=1 constantly, Imem_Rdata=32'h2002_0005 → Imem_Addr 0,4,8 on successive cycles; PC_4 4,8,C; IF_stall=0 throughout.
- At PC 8, Imem_Ack held low 3 cycles → IF_stall=1 for 3 cycles with PC_IF=8; on Ack, Inst=Imem_Rdata, IF_stall=0, and the next PC is C.
- Ack with Rdata=32'h8C43_0010 while Stall_ID=1 for 2 cycles, Rdata then changes to 32'hFFFF_FFFF → S_HOLD; Inst stays 32'h8C43_0010; on Stall_ID=0, PC advances by 4 and Imem_Req returns to 1.
- Jump=1, PC_ID=32'h1000_0004, Jump_Target=26'h000_0040, concurrent Branch_Taken=1 → IF_Flush=1 that cycle; next Imem_Addr=32'h1000_0100 (Jump wins over Branch). Repeat with Jr=1, Jr_Target=32'h0000_2003 → next Imem_Addr=32'h0000_2000.
- Jump=1 with Stall_ID=1 → IF_Flush=0 and PC unchanged. Separately, PC_IF=32'hFFFF_FFFC with Ack → next PC_IF=32'h0000_0000; assert Rst_n during a waiting fetch → PC_IF=RESET_PC immediately.
